// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD raster timing generator: pixel divider, h/v counters, registered syncs and strobes.
// Optional VGA_TIMING_LOOKAHEAD_EN adds next_x/next_y/next_active for one-pixel-early RAM reads.
module vga_timing_gen #(
    parameter int unsigned HACTIVE = 640,
    parameter int unsigned HFP     = 16,
    parameter int unsigned HSYNC   = 96,
    parameter int unsigned HBP     = 48,
    parameter int unsigned VACTIVE = 480,
    parameter int unsigned VFP     = 10,
    parameter int unsigned VSYNC   = 2,
    parameter int unsigned VBP     = 33,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned HS_POL  = 0,
    parameter int unsigned VS_POL  = 0,
    parameter int unsigned FCNT_W  = 8,
    localparam int unsigned HTOTAL = HACTIVE + HFP + HSYNC + HBP,
    localparam int unsigned VTOTAL = VACTIVE + VFP + VSYNC + VBP,
    localparam int unsigned HW     = $clog2(HTOTAL),
    localparam int unsigned VW     = $clog2(VTOTAL)
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic              run,
    output logic              pix_ce,
    output logic [HW-1:0]     hcount,
    output logic [VW-1:0]     vcount,
    output logic              active,
    output logic              sol,
    output logic              sof,
    output logic              end_of_field,
    output logic [FCNT_W-1:0] frame_count,
    output logic              VGA_CLK,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_n,
    output logic              VGA_SYNC_n
`ifdef VGA_TIMING_LOOKAHEAD_EN
    ,
    output logic [HW-1:0]     next_x,
    output logic [VW-1:0]     next_y,
    output logic              next_active
`endif
);

    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned HX = HW + 1;
    localparam int unsigned VX = VW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
    // One extra bit so window ends equal to 2^HW / 2^VW do not truncate
    localparam logic [HX-1:0] H_ACT    = HX'(HACTIVE);
    localparam logic [HX-1:0] H_SS     = HX'(HACTIVE + HFP);
    localparam logic [HX-1:0] H_SE     = HX'(HACTIVE + HFP + HSYNC);
    localparam logic [VX-1:0] V_ACT    = VX'(VACTIVE);
    localparam logic [VX-1:0] V_SS     = VX'(VACTIVE + VFP);
    localparam logic [VX-1:0] V_SE     = VX'(VACTIVE + VFP + VSYNC);
    localparam logic          HS_LVL   = (HS_POL != 0);
    localparam logic          VS_LVL   = (VS_POL != 0);

    logic [DW-1:0]     r_div;
    logic              r_first;
    logic              r_pix_ce;
    logic [HW-1:0]     r_hcount;
    logic [VW-1:0]     r_vcount;
    logic              r_active;
    logic              r_sol;
    logic              r_sof;
    logic              r_eof;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_vga_clk;
    logic              r_hs;
    logic              r_vs;

    logic              w_slot;
    logic [DW-1:0]     w_div_nxt;
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic [HW-1:0]     w_h_nxt;
    logic [VW-1:0]     w_v_nxt;
    logic [HX-1:0]     w_hx;
    logic [VX-1:0]     w_vx;
    logic              w_act_nxt;
    logic              w_hs_win;
    logic              w_vs_win;

    // Next divider/count values; the first slot after reset shows (0,0) without advancing
    always_comb begin
        w_slot    = run && (r_div == '0);
        w_div_nxt = r_div;
        if (run) begin
            w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
        w_h_wrap = w_slot && !r_first && (r_hcount == H_LAST);
        w_v_wrap = w_h_wrap && (r_vcount == V_LAST);
        w_h_nxt  = r_hcount;
        w_v_nxt  = r_vcount;
        if (w_slot && !r_first) begin
            w_h_nxt = w_h_wrap ? '0 : r_hcount + 1'b1;
            if (w_h_wrap) begin
                w_v_nxt = w_v_wrap ? '0 : r_vcount + 1'b1;
            end
        end
        w_hx      = {1'b0, w_h_nxt};
        w_vx      = {1'b0, w_v_nxt};
        w_act_nxt = (w_hx < H_ACT) && (w_vx < V_ACT);
        w_hs_win  = (w_hx >= H_SS) && (w_hx < H_SE);
        w_vs_win  = (w_vx >= V_SS) && (w_vx < V_SE);
    end

    // Counters and decoded outputs share one edge so outputs carry no latency vs. the counts
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_div     <= '0;
            r_first   <= 1'b1;
            r_pix_ce  <= 1'b0;
            r_hcount  <= '0;
            r_vcount  <= '0;
            r_active  <= 1'b1;
            r_sol     <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_fcnt    <= '0;
            r_vga_clk <= 1'b0;
            r_hs      <= ~HS_LVL;
            r_vs      <= ~VS_LVL;
        end else begin
            r_pix_ce <= w_slot;
            r_sol    <= w_slot && (w_h_nxt == '0);
            r_sof    <= w_slot && (w_h_nxt == '0) && (w_v_nxt == '0);
            if (run) begin
                r_div     <= w_div_nxt;
                r_vga_clk <= (r_div >= DIV_HALF);
            end
            if (w_slot) begin
                r_first <= 1'b0;
            end
            if (w_v_wrap) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            r_hcount <= w_h_nxt;
            r_vcount <= w_v_nxt;
            r_active <= w_act_nxt;
            r_eof    <= (w_v_nxt == V_LAST);
            r_hs     <= w_hs_win ? HS_LVL : ~HS_LVL;
            r_vs     <= w_vs_win ? VS_LVL : ~VS_LVL;
        end
    end

    assign pix_ce       = r_pix_ce;
    assign hcount       = r_hcount;
    assign vcount       = r_vcount;
    assign active       = r_active;
    assign sol          = r_sol;
    assign sof          = r_sof;
    assign end_of_field = r_eof;
    assign frame_count  = r_fcnt;
    assign VGA_CLK      = r_vga_clk;
    assign VGA_HS       = r_hs;
    assign VGA_VS       = r_vs;
    assign VGA_BLANK_n  = r_active;
    assign VGA_SYNC_n   = 1'b0;

`ifdef VGA_TIMING_LOOKAHEAD_EN
    logic [HW-1:0] r_nx;
    logic [VW-1:0] r_ny;
    logic          r_nact;
    logic [HW-1:0] w_la_x;
    logic [VW-1:0] w_la_y;

    // Coordinate one slot beyond the pixel being presented
    always_comb begin
        w_la_x = (w_h_nxt == H_LAST) ? '0 : w_h_nxt + 1'b1;
        w_la_y = w_v_nxt;
        if (w_h_nxt == H_LAST) begin
            w_la_y = (w_v_nxt == V_LAST) ? '0 : w_v_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_nx   <= '0;
            r_ny   <= '0;
            r_nact <= 1'b1;
        end else if (w_slot) begin
            r_nx   <= w_la_x;
            r_ny   <= w_la_y;
            r_nact <= ({1'b0, w_la_x} < H_ACT) && ({1'b0, w_la_y} < V_ACT);
        end
    end

    assign next_x      = r_nx;
    assign next_y      = r_ny;
    assign next_active = r_nact;
`endif

endmodule
